// File: rtl/sum_pkg.sv
// Shared helpers for sum_pipe: segment geometry of the split carry chain and
// the parameter legality check used at elaboration.
package sum_pkg;

   localparam int SEG_MIN = 1;

   function automatic int chunk_width(input int width, input int seg);
      return (width + seg - 1) / seg;
   endfunction

   function automatic int seg_lo(input int k, input int chunk);
      return k * chunk;
   endfunction

   function automatic int seg_hi(input int k, input int chunk, input int width);
      int hi;
      hi = (k + 1) * chunk;
      if (hi > width) hi = width;
      return hi - 1;
   endfunction

   // Legal when 1 <= seg <= width and the last segment still owns at least one bit.
   function automatic bit seg_cfg_ok(input int width, input int seg);
      if (seg < SEG_MIN || seg > width) return 1'b0;
      return seg_lo(seg - 1, chunk_width(width, seg)) < width;
   endfunction

endpackage

// File: rtl/sum_seg_stage.sv
// One carry segment of sum_pipe: segment adder plus valid/operand/sum/carry registers.
// With SUM_PIPE_SIGNED_EN defined, the final segment sign-extends its operands.
module sum_seg_stage
   import sum_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int SEG   = 2,
   parameter int K     = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   input  logic             en_next,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [WIDTH-1:0] sum_in,
   input  logic             c_in,
   output logic             en,
   output logic             v_q,
   output logic [WIDTH-1:0] a_q,
   output logic [WIDTH-1:0] b_q,
   output logic [WIDTH-1:0] sum_q,
   output logic             c_q
);

   localparam int CHUNK = chunk_width(WIDTH, SEG);
   localparam int LO    = seg_lo(K, CHUNK);
   localparam int HI    = seg_hi(K, CHUNK, WIDTH);
   localparam int SW    = HI - LO + 1;
`ifdef SUM_PIPE_SIGNED_EN
   localparam bit LAST  = (K == SEG - 1);
`endif

   logic             v_d;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] b_d;
   logic [WIDTH-1:0] sum_d;
   logic             c_d;
   logic [SW:0]      seg_sum;
   logic             ext_a;
   logic             ext_b;

   assign en = ~v_q | en_next;

   always_comb begin
      ext_a = 1'b0;
      ext_b = 1'b0;
`ifdef SUM_PIPE_SIGNED_EN
      // The extra bit of the top segment becomes the true sign of the result.
      if (LAST) begin
         ext_a = a_in[HI];
         ext_b = b_in[HI];
      end
`endif
      seg_sum = {ext_a, a_in[HI:LO]} + {ext_b, b_in[HI:LO]} + {{SW{1'b0}}, c_in};
      v_d     = en ? up_valid : v_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      c_d     = c_q;
      if (en && up_valid) begin
         a_d            = a_in;
         b_d            = b_in;
         sum_d          = sum_in;
         sum_d[HI:LO]   = seg_sum[SW-1:0];
         c_d            = seg_sum[SW];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q   <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         sum_q <= '0;
         c_q   <= 1'b0;
      end else begin
         v_q   <= v_d;
         a_q   <= a_d;
         b_q   <= b_d;
         sum_q <= sum_d;
         c_q   <= c_d;
      end
   end

endmodule

// File: rtl/sum_pipe.sv
// Pipelined WIDTH-bit adder, carry chain split into SEG registered segments with
// valid/ready backpressure. Define SUM_PIPE_SIGNED_EN for two's-complement operands.
module sum_pipe
   import sum_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int SEG   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   s
);

   if (!seg_cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
      $error("sum_pipe: SEG=%0d illegal for WIDTH=%0d (empty segment or out of range)", SEG, WIDTH);
   end

   logic [SEG:0]              v_c;
   logic [SEG:0]              c_c;
   logic [SEG:0][WIDTH-1:0]   a_c;
   logic [SEG:0][WIDTH-1:0]   b_c;
   logic [SEG:0][WIDTH-1:0]   sum_c;
   logic [SEG-1:0]            en_c;
   logic [SEG-1:0]            en_next_c;
   logic                      unused_ok;

   assign v_c[0]   = in_valid;
   assign a_c[0]   = a;
   assign b_c[0]   = b;
   assign sum_c[0] = '0;
   assign c_c[0]   = 1'b0;

   for (genvar k = 0; k < SEG; k++) begin : g_stage
      // Downstream enable in closed form: a stage can move unless every later stage is full and stalled.
      if (k == SEG - 1) begin : g_last
         assign en_next_c[k] = out_ready;
      end else begin : g_mid
         assign en_next_c[k] = out_ready | ~(&v_c[SEG:k+2]);
      end

      sum_seg_stage #(
         .WIDTH (WIDTH),
         .SEG   (SEG),
         .K     (k)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .up_valid (v_c[k]),
         .en_next  (en_next_c[k]),
         .a_in     (a_c[k]),
         .b_in     (b_c[k]),
         .sum_in   (sum_c[k]),
         .c_in     (c_c[k]),
         .en       (en_c[k]),
         .v_q      (v_c[k+1]),
         .a_q      (a_c[k+1]),
         .b_q      (b_c[k+1]),
         .sum_q    (sum_c[k+1]),
         .c_q      (c_c[k+1])
      );
   end

   assign in_ready  = en_c[0];
   assign out_valid = v_c[SEG];
   assign s         = {c_c[SEG], sum_c[SEG]};
   assign unused_ok = ^{a_c[SEG], b_c[SEG], en_c};

endmodule

// File: tb/tb_sum_pipe.sv
// Self-checking bench for sum_pipe (WIDTH=9, SEG=3) plus SEG=1 and SEG=WIDTH instances.
module tb_sum_pipe;

   localparam int W = 9;
   localparam int S = 3;

`ifdef SUM_PIPE_SIGNED_EN
   localparam logic [W:0] EXP_CARRY = 10'h000;
   localparam logic [W:0] EXP_AA    = 10'h3FF;
`else
   localparam logic [W:0] EXP_CARRY = 10'h200;
   localparam logic [W:0] EXP_AA    = 10'h1FF;
`endif

   typedef struct {
      logic [W:0] s;
      int         c;
   } item_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] a, b;
   logic [W:0]   s;
   logic         x_valid, x_ready, rdy1, rdy9, ov1, ov9;
   logic [W-1:0] xa, xb;
   logic [W:0]   s1, s9;

   sum_pipe #(.WIDTH(W), .SEG(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .s(s));

   sum_pipe #(.WIDTH(W), .SEG(1)) dut_seg1 (
      .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(rdy1), .a(xa), .b(xb),
      .out_valid(ov1), .out_ready(x_ready), .s(s1));

   sum_pipe #(.WIDTH(W), .SEG(W)) dut_segw (
      .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(rdy9), .a(xa), .b(xb),
      .out_valid(ov9), .out_ready(x_ready), .s(s9));

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         run = 0;
   int         max_run = 0;
   item_t      q[$];
   logic [W:0] got[$];
   logic       exp_v;

   function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SUM_PIPE_SIGNED_EN
      return {x[W-1], x} + {y[W-1], y};
`else
      return {1'b0, x} + {1'b0, y};
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: items in flight in order; the oldest is presented SEG cycles after it was offered.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         run = 0;
      end else begin
         exp_v = (q.size() > 0) && (cyc - q[0].c >= S);
         chk("out_valid", out_valid, exp_v);
         chk("in_ready", in_ready, (q.size() < S) || out_ready);
         if (out_valid && q.size() > 0) chk("s", s, q[0].s);
         if (out_valid && out_ready && q.size() > 0) begin
            got.push_back(s);
            void'(q.pop_front());
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         if (in_valid && in_ready) q.push_back('{s: ref_sum(a, b), c: cyc});
      end
   end

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
      int   n;
      logic acc;
      n        = 0;
      acc      = 1'b0;
      in_valid = 1'b1;
      a        = x;
      b        = y;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic lat_check(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W:0] exp);
      send(x, y);
      for (int i = 0; i < S - 1; i++) begin
         chk({name, "_early"}, out_valid, 1'b0);
         @(posedge clk);
         #1;
      end
      chk({name, "_valid"}, out_valid, 1'b1);
      chk({name, "_s"}, s, exp);
   endtask

   initial begin
      int         l1, l9;
      logic [W:0] c1, c9;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;
      x_valid   = 1'b0;
      x_ready   = 1'b1;
      xa        = '0;
      xb        = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_s", s, '0);
      #2 rst = 1'b0;
      #1 chk("ready_after_rst", in_ready, 1'b1);

      lat_check("max_operands", 9'h1FF, 9'h1FF, 10'h3FE);
      repeat (3) @(posedge clk);
      #1;
      lat_check("carry_chain", 9'h1FF, 9'h001, EXP_CARRY);
      repeat (3) @(posedge clk);
      #1;

      got.delete();
      fork
         begin
            for (int k = 1; k <= 5; k++) send(W'(k), W'(k));
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(posedge clk);
               #1;
               chk("bp_in_ready", in_ready, 1'b0);
               chk("bp_hold_valid", out_valid, 1'b1);
               chk("bp_hold_s", s, 10'd2);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      #1;
      chk("bp_count", got.size(), 5);
      for (int k = 0; k < 5; k++)
         chk("bp_order", (k < got.size()) ? got[k] : 10'h3FF, 10'(2 * (k + 1)));

      run     = 0;
      max_run = 0;
      for (int i = 0; i < 20; i++) send(W'($urandom_range(0, 511)), W'($urandom_range(0, 511)));
      repeat (5) @(posedge clk);
      #1;
      chk("throughput_run", max_run, 20);

      send(9'd1, 9'd2);
      send(9'd3, 9'd4);
      send(9'd5, 9'd6);
      chk("pre_rst_valid", out_valid, 1'b1);
      chk("pre_rst_s", s, 10'd3);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_s", s, '0);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk("ready_after_mid_rst", in_ready, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      lat_check("post_rst", 9'h0AA, 9'h155, EXP_AA);
      repeat (3) @(posedge clk);
      #1;

      xa      = 9'h0AA;
      xb      = 9'h155;
      x_valid = 1'b1;
      @(negedge clk);
      chk("seg1_ready", rdy1, 1'b1);
      chk("segw_ready", rdy9, 1'b1);
      @(posedge clk);
      #1 x_valid = 1'b0;
      l1 = 0;
      l9 = 0;
      c1 = '0;
      c9 = '0;
      for (int n = 1; n <= 12; n++) begin
         if (ov1 && l1 == 0) begin
            l1 = n;
            c1 = s1;
         end
         if (ov9 && l9 == 0) begin
            l9 = n;
            c9 = s9;
         end
         @(posedge clk);
         #1;
      end
      chk("seg1_latency", l1, 1);
      chk("segw_latency", l9, W);
      chk("seg1_s", c1, EXP_AA);
      chk("segw_s", c9, EXP_AA);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
